// File: rtl/module_bcd_a_binario.sv
// Purpose: converts four BCD digits (0000-9999) into a WIDTH-bit unsigned binary value.
// Latency: done pulses for the cycle after the 6th edge counting the accepting edge (1 check + 4 digit steps).
// Backpressure: start is only sampled while idle; requests made while busy are dropped, not queued.
module module_bcd_a_binario #(
    // Must be at least 14 so that 9999 fits without overflow.
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       unidades_input,
    input  logic [3:0]       decenas_input,
    input  logic [3:0]       centenas_input,
    input  logic [3:0]       milesimas_input,
    output logic [WIDTH-1:0] numero_output,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CALC  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [1:0]       idx;
    // Digit slot 3 holds thousands, slot 0 holds units.
    logic [3:0][3:0]  digit_q;

    logic [3:0]       cur_digit;
    logic [WIDTH-1:0] acc_next;
    logic             digit_invalid;

    // Select the digit being folded in and form acc*10 + digit with shifts only.
    always_comb begin
        cur_digit = digit_q[idx];
        acc_next  = (acc << 3) + (acc << 1) + {{(WIDTH-4){1'b0}}, cur_digit};
    end

    // Any latched digit above 9 makes the whole request invalid.
    always_comb begin
        digit_invalid = (digit_q[3] > 4'd9) || (digit_q[2] > 4'd9) ||
                        (digit_q[1] > 4'd9) || (digit_q[0] > 4'd9);
    end

    // Control FSM with registered outputs; done defaults low so it only pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            idx           <= '0;
            digit_q       <= '0;
            numero_output <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        digit_q[3] <= milesimas_input;
                        digit_q[2] <= centenas_input;
                        digit_q[1] <= decenas_input;
                        digit_q[0] <= unidades_input;
                        acc        <= '0;
                        idx        <= 2'd3;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (digit_invalid) begin
                        // Previous result is deliberately left untouched.
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (idx == 2'd0) begin
                        numero_output <= acc_next;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        idx <= idx - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_bcd_a_binario.sv
// Purpose: directed self-checking bench for the BCD to binary converter.
// Latency: expects done 5 edges after the accepting edge (1 for invalid digits).
// Backpressure: exercises ignored start while busy and back-to-back held start.
module tb_module_bcd_a_binario;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  unidades_input;
    logic [3:0]  decenas_input;
    logic [3:0]  centenas_input;
    logic [3:0]  milesimas_input;
    logic [15:0] numero_output;
    logic        busy;
    logic        done;
    logic        error;

    int vectors;
    int miscompares;

    module_bcd_a_binario #(.WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .unidades_input  (unidades_input),
        .decenas_input   (decenas_input),
        .centenas_input  (centenas_input),
        .milesimas_input (milesimas_input),
        .numero_output   (numero_output),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request packed as thousands..units nibbles, then waits (bounded) for done.
    // lat is the number of edges after the accepting edge; -1 means timeout.
    task automatic run_conv(input logic [15:0] bcd, output int lat,
                            output logic [15:0] res, output logic err,
                            output logic busy_acc);
        @(negedge clk);
        milesimas_input = bcd[15:12];
        centenas_input  = bcd[11:8];
        decenas_input   = bcd[7:4];
        unidades_input  = bcd[3:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_acc = busy;
        // Inputs may change after acceptance; scramble them.
        milesimas_input = 4'd2;
        centenas_input  = 4'd2;
        decenas_input   = 4'd2;
        unidades_input  = 4'd2;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        res = numero_output;
        err = error;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        unidades_input = 4'd0;
        decenas_input = 4'd0;
        centenas_input = 4'd0;
        milesimas_input = 4'd0;
        @(posedge clk);
        #1;
        vectors++;
        if ({numero_output, busy, done, error} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state: got num=%0d busy=%b done=%b err=%b, want all 0",
                     numero_output, busy, done, error);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({numero_output, busy, done, error} !== 19'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got num=%0d busy=%b done=%b err=%b, want all 0",
                     numero_output, busy, done, error);
        end
    endtask

    task automatic test_basic();
        logic [15:0] bcd_tab [5];
        logic [15:0] exp_tab [5];
        int          lat;
        logic [15:0] res;
        logic        err;
        logic        b;
        bcd_tab = '{16'h1007, 16'h5004, 16'h4346, 16'h9999, 16'h0000};
        exp_tab = '{16'd1007, 16'd5004, 16'd4346, 16'h270F, 16'd0};
        for (int v = 0; v < 5; v++) begin
            run_conv(bcd_tab[v], lat, res, err, b);
            vectors++;
            if (lat != 5 || res !== exp_tab[v] || err !== 1'b0) begin
                miscompares++;
                $display("FAIL conv_%h: got lat=%0d num=%0d err=%b, want lat=5 num=%0d err=0",
                         bcd_tab[v], lat, res, err, exp_tab[v]);
            end
            vectors++;
            if (b !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_on_accept_%h: got %b, want 1", bcd_tab[v], b);
            end
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_at_done_%h: got %b, want 0", bcd_tab[v], busy);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b0 || numero_output !== exp_tab[v]) begin
                miscompares++;
                $display("FAIL done_pulse_%h: got done=%b num=%0d, want done=0 num=%0d",
                         bcd_tab[v], done, numero_output, exp_tab[v]);
            end
        end
    endtask

    task automatic test_error();
        int          lat;
        logic [15:0] res;
        logic        err;
        logic        b;
        run_conv(16'h1007, lat, res, err, b);
        vectors++;
        if (res !== 16'd1007) begin
            miscompares++;
            $display("FAIL err_setup: got num=%0d, want 1007", res);
        end
        run_conv(16'hA000, lat, res, err, b);
        vectors++;
        if (lat != 1 || err !== 1'b1 || res !== 16'd1007 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_digit: got lat=%0d err=%b num=%0d busy=%b, want lat=1 err=1 num=1007 busy=0",
                     lat, err, res, busy);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || error !== 1'b1) begin
            miscompares++;
            $display("FAIL error_hold: got done=%b err=%b, want done=0 err=1", done, error);
        end
        run_conv(16'h0309, lat, res, err, b);
        vectors++;
        if (lat != 5 || err !== 1'b0 || res !== 16'd309) begin
            miscompares++;
            $display("FAIL error_clear: got lat=%0d err=%b num=%0d, want lat=5 err=0 num=309",
                     lat, err, res);
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        @(negedge clk);
        {milesimas_input, centenas_input, decenas_input, unidades_input} = 16'h2468;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        // Second request two cycles into the conversion, different digits.
        {milesimas_input, centenas_input, decenas_input, unidades_input} = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (dones != 1 || numero_output !== 16'd2468) begin
            miscompares++;
            $display("FAIL ignore_start: got dones=%0d num=%0d, want dones=1 num=2468",
                     dones, numero_output);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        first_done  = -1;
        second_done = -1;
        @(negedge clk);
        {milesimas_input, centenas_input, decenas_input, unidades_input} = 16'h0042;
        start = 1'b1;
        // Edge 0 is the first accepting edge.
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first_done < 0) first_done = i;
                else begin
                    second_done = i;
                    start = 1'b0;
                    break;
                end
            end
        end
        vectors++;
        if (first_done != 5 || second_done != 11 || numero_output !== 16'd42) begin
            miscompares++;
            $display("FAIL back_to_back: got done at %0d,%0d num=%0d, want 5,11 num=42",
                     first_done, second_done, numero_output);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_stop: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int          dones;
        int          lat;
        logic [15:0] res;
        logic        err;
        logic        b;
        @(negedge clk);
        {milesimas_input, centenas_input, decenas_input, unidades_input} = 16'h7777;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Two more edges: CHECK then first CALC step.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || numero_output !== 16'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b num=%0d done=%b, want 0,0,0",
                     busy, numero_output, done);
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", dones);
        end
        run_conv(16'h1208, lat, res, err, b);
        vectors++;
        if (lat != 5 || res !== 16'd1208 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_conv: got lat=%0d num=%0d err=%b, want lat=5 num=1208 err=0",
                     lat, res, err);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_error();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
